reg_wb_arbiter: RTL and testbench

- Write-side front end for the 32x32 register file.
- Accepts register write-back requests from two producers, the ALU (source A, higher priority) and the load unit (source B), over valid/ready handshakes.
- Buffers accepted requests in a small FIFO and drives the register file's single write port (waddr/wen/wdata) at one write per cycle.
- Reports pending-write hazards on two probe addresses so the issue stage can stall reads of stale registers.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/reg_wb_arbiter_if.sv | 60 ++++++
 rtl/wb_fifo.sv | 75 +++++++
 rtl/reg_wb_arbiter.sv | 133 +++++++++++++
 tb/tb_reg_wb_arbiter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the register write-back arbiter.
// Holds the default bus widths, the FIFO depth and the buffered entry layout.
package wb_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int DEPTH      = 4;

    // One buffered register write: destination register and the value to store.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wb_entry;

    // Register 0 is hard-wired, so a write to it carries no effect and is dropped.
    function automatic logic writes_reg(input logic [ADDR_WIDTH-1:0] addr);
        return addr != '0;
    endfunction

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// Bundle of the producer handshakes, register file write port, hazard probes
// and status outputs of the write-back arbiter.
// The master side drives requests and probes; the slave side is the arbiter.
interface reg_wb_arbiter_if #(
    parameter int DATA_WIDTH = wb_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = wb_pkg::ADDR_WIDTH,
    parameter int DEPTH      = wb_pkg::DEPTH
);
    import wb_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    // ALU request channel (higher priority)
    logic                  a_valid;
    logic                  a_ready;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_data;

    // Load-unit request channel
    logic                  b_valid;
    logic                  b_ready;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_data;

    // Register file write port
    logic [ADDR_WIDTH-1:0] waddr;
    logic                  wen;
    logic [DATA_WIDTH-1:0] wdata;

    // Hazard probes from the issue stage
    logic [ADDR_WIDTH-1:0] chk_addr1;
    logic [ADDR_WIDTH-1:0] chk_addr2;
    logic                  chk_busy1;
    logic                  chk_busy2;

    // Status
    logic [CW-1:0]         count;
    logic                  idle;

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        output chk_addr1, chk_addr2,
        input  a_ready, b_ready,
        input  waddr, wen, wdata,
        input  chk_busy1, chk_busy2,
        input  count, idle
    );

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        input  chk_addr1, chk_addr2,
        output a_ready, b_ready,
        output waddr, wen, wdata,
        output chk_busy1, chk_busy2,
        output count, idle
    );

endinterface

// File: rtl/wb_fifo.sv
// Circular buffer of pending register writes.
// Takes up to two ordered pushes per edge (slot 0 lands before slot 1) and
// releases at most one entry per edge from the head. Occupancy and per-slot
// addresses are exposed so the top level can flag read-after-write hazards.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = wb_pkg::DEPTH
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    push0_en,
    input  wb_entry                                 push0,
    input  logic                                    push1_en,
    input  wb_entry                                 push1,
    input  logic                                    pop_en,
    output wb_entry                                 head,
    output logic [$clog2(DEPTH):0]                  count,
    output logic [DEPTH-1:0]                        ent_valid,
    output logic [DEPTH-1:0][wb_pkg::ADDR_WIDTH-1:0] ent_addr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry       mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] push_cnt;

    assign push_cnt = CW'(push0_en) + CW'(push1_en);

    // Storage writes; slot 1 always follows slot 0 so order within an edge is kept.
    // Entries carry no reset because every reader qualifies them with occupancy.
    always_ff @(posedge clk) begin
        if (push0_en) begin
            mem[wr_ptr] <= push0;
        end
        if (push1_en) begin
            mem[wr_ptr + PW'(1)] <= push1;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            wr_ptr  <= wr_ptr + PW'(push_cnt);
            if (pop_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count_q <= count_q + push_cnt - CW'(pop_en);
        end
    end

    // A slot is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        ent_valid = '0;
        ent_addr  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PW-1:0] offset;
            offset       = PW'(i) - rd_ptr;
            ent_valid[i] = ({1'b0, offset} < count_q);
            ent_addr[i]  = mem[i].addr;
        end
    end

    assign head  = mem[rd_ptr];
    assign count = count_q;

endmodule

// File: rtl/reg_wb_arbiter.sv
// Write-side front end for the 32x32 register file.
// Arbitrates ALU (A) and load-unit (B) write-back requests, drops writes to
// register 0, buffers the rest in wb_fifo, and drives the single registered
// write port at one write per cycle. Two combinational probes tell the issue
// stage whether a register still has a write in flight.
module reg_wb_arbiter #(
    parameter int DATA_WIDTH = wb_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = wb_pkg::ADDR_WIDTH,
    parameter int DEPTH      = wb_pkg::DEPTH
) (
    input logic             clk,
    input logic             rst,
    reg_wb_arbiter_if.slave bus
);
    import wb_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]                           count;
    logic [CW-1:0]                           free;
    logic                                    a_ready;
    logic                                    b_ready;
    logic                                    a_nonzero;
    logic                                    b_nonzero;
    logic                                    take_a;
    logic                                    take_b;
    logic                                    push0_en;
    logic                                    push1_en;
    logic                                    pop_en;
    wb_entry                                 a_entry;
    wb_entry                                 b_entry;
    wb_entry                                 push0;
    wb_entry                                 push1;
    wb_entry                                 head;
    logic [DEPTH-1:0]                        ent_valid;
    logic [DEPTH-1:0][wb_pkg::ADDR_WIDTH-1:0] ent_addr;
    logic                                    wen_q;
    logic [ADDR_WIDTH-1:0]                   waddr_q;
    logic [DATA_WIDTH-1:0]                   wdata_q;
    logic                                    hit1;
    logic                                    hit2;

    assign a_nonzero = writes_reg(bus.a_addr);
    assign b_nonzero = writes_reg(bus.b_addr);
    assign a_entry   = '{addr: bus.a_addr, data: bus.a_data};
    assign b_entry   = '{addr: bus.b_addr, data: bus.b_data};

    // Readiness from pre-edge occupancy only; B yields its last free slot to a real A write.
    always_comb begin
        free    = CW'(DEPTH) - count;
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (rst) begin
            a_ready = (free >= CW'(1));
            b_ready = (free >= CW'(2)) || ((free >= CW'(1)) && !(bus.a_valid && a_nonzero));
        end
    end

    assign take_a = bus.a_valid && a_ready && a_nonzero;
    assign take_b = bus.b_valid && b_ready && b_nonzero;

    // Map accepted requests onto the ordered push slots; A always takes the lower slot.
    always_comb begin
        push0_en = take_a || take_b;
        push0    = take_a ? a_entry : b_entry;
        push1_en = take_a && take_b;
        push1    = b_entry;
    end

    assign pop_en = (count != '0);

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push0_en  (push0_en),
        .push0     (push0),
        .push1_en  (push1_en),
        .push1     (push1),
        .pop_en    (pop_en),
        .head      (head),
        .count     (count),
        .ent_valid (ent_valid),
        .ent_addr  (ent_addr)
    );

    // Register-file write port: load the head whenever one is popped, otherwise drop wen and hold the rest.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else if (pop_en) begin
            wen_q   <= 1'b1;
            waddr_q <= head.addr;
            wdata_q <= head.data;
        end else begin
            wen_q   <= 1'b0;
        end
    end

    // Hazard compare against every live buffered entry plus the write currently on the port.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_addr[i] == bus.chk_addr1)) begin
                hit1 = 1'b1;
            end
            if (ent_valid[i] && (ent_addr[i] == bus.chk_addr2)) begin
                hit2 = 1'b1;
            end
        end
        if (wen_q && (waddr_q == bus.chk_addr1)) begin
            hit1 = 1'b1;
        end
        if (wen_q && (waddr_q == bus.chk_addr2)) begin
            hit2 = 1'b1;
        end
    end

    assign bus.a_ready   = a_ready;
    assign bus.b_ready   = b_ready;
    assign bus.wen       = wen_q;
    assign bus.waddr     = waddr_q;
    assign bus.wdata     = wdata_q;
    assign bus.count     = count;
    assign bus.idle      = (count == '0) && !wen_q;
    assign bus.chk_busy1 = rst && writes_reg(bus.chk_addr1) && hit1;
    assign bus.chk_busy2 = rst && writes_reg(bus.chk_addr2) && hit2;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Testbench for reg_wb_arbiter.
// A queue-based reference model tracks accepted writes; each write handed to
// the register file is pushed onto a scoreboard that a separate monitor drains
// whenever the DUT raises wen.
module tb_reg_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DP = wb_pkg::DEPTH;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    reg_wb_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP)) bus ();

    reg_wb_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    wr_t           pending[$];
    wr_t           expected[$];
    bit            m_wen;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    int            checks = 0;
    int            errors = 0;
    bit            acc_a;
    bit            acc_b;

    function automatic void compare(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Readiness from the number of free slots in the model queue.
    function automatic void readyModel(output bit ar, output bit br);
        int free_slots;
        free_slots = DP - pending.size();
        ar = (rst === 1'b1) && (free_slots >= 1);
        br = (rst === 1'b1) && ((free_slots >= 2) ||
             ((free_slots >= 1) && !(bus.a_valid && (bus.a_addr != '0))));
    endfunction

    function automatic bit busyModel(logic [AW-1:0] c);
        if ((rst !== 1'b1) || (c == '0)) return 1'b0;
        foreach (pending[i]) begin
            if (pending[i].addr == c) return 1'b1;
        end
        return m_wen && (m_waddr == c);
    endfunction

    task automatic checkOutput();
        bit ar;
        bit br;
        readyModel(ar, br);
        compare("a_ready",   64'(bus.a_ready),   64'(ar));
        compare("b_ready",   64'(bus.b_ready),   64'(br));
        compare("count",     64'(bus.count),     64'(pending.size()));
        compare("idle",      64'(bus.idle),      64'((pending.size() == 0) && !m_wen));
        compare("wen",       64'(bus.wen),       64'(m_wen));
        compare("waddr",     64'(bus.waddr),     64'(m_waddr));
        compare("wdata",     64'(bus.wdata),     64'(m_wdata));
        compare("chk_busy1", 64'(bus.chk_busy1), 64'(busyModel(bus.chk_addr1)));
        compare("chk_busy2", 64'(bus.chk_busy2), 64'(busyModel(bus.chk_addr2)));
    endtask

    task automatic applyStimulus(input bit r,
                                 input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                                 input bit bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                                 input logic [AW-1:0] c1, input logic [AW-1:0] c2);
        bit  ar;
        bit  br;
        wr_t e;
        @(negedge clk);
        rst           = r;
        bus.a_valid   = av;
        bus.a_addr    = aa;
        bus.a_data    = ad;
        bus.b_valid   = bv;
        bus.b_addr    = ba;
        bus.b_data    = bd;
        bus.chk_addr1 = c1;
        bus.chk_addr2 = c2;
        #1;
        checkOutput();
        readyModel(ar, br);
        acc_a = av && ar;
        acc_b = bv && br;
        @(posedge clk);
        if (!r) begin
            pending.delete();
            m_wen   = 1'b0;
            m_waddr = '0;
            m_wdata = '0;
        end else begin
            if (pending.size() > 0) begin
                e       = pending.pop_front();
                m_wen   = 1'b1;
                m_waddr = e.addr;
                m_wdata = e.data;
                expected.push_back(e);
            end else begin
                m_wen = 1'b0;
            end
            if (acc_a && (aa != '0)) pending.push_back('{aa, ad});
            if (acc_b && (ba != '0)) pending.push_back('{ba, bd});
        end
    endtask

    task automatic idleCycles(input int n, input logic [AW-1:0] c1, input logic [AW-1:0] c2);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, c1, c2);
        end
    endtask

    // Keep offering both requests until each has been accepted, within a bounded number of cycles.
    task automatic sendPair(input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                            input logic [AW-1:0] ba, input logic [DW-1:0] bd);
        bit need_a;
        bit need_b;
        int tries;
        need_a = 1'b1;
        need_b = 1'b1;
        tries  = 0;
        while ((need_a || need_b) && (tries < 8)) begin
            applyStimulus(1'b1, need_a, aa, ad, need_b, ba, bd, aa, ba);
            if (acc_a) need_a = 1'b0;
            if (acc_b) need_b = 1'b0;
            tries++;
        end
        compare("pair_accept_timeout", 64'(need_a || need_b), 64'(0));
    endtask

    // Scoreboard monitor: every cycle the DUT writes, the oldest expected write must match.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            #2;
            if (bus.wen === 1'b1) begin
                if (expected.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                             bus.waddr, bus.wdata);
                end else begin
                    e = expected.pop_front();
                    compare("sb_waddr", 64'(bus.waddr), 64'(e.addr));
                    compare("sb_wdata", 64'(bus.wdata), 64'(e.data));
                end
            end
        end
    end

    initial begin
        bit            r;
        bit            av;
        bit            bv;
        logic [AW-1:0] aa;
        logic [AW-1:0] ba;
        logic [AW-1:0] c1;
        logic [AW-1:0] c2;
        logic [DW-1:0] ad;
        logic [DW-1:0] bd;

        bus.a_valid   = 1'b0;
        bus.a_addr    = '0;
        bus.a_data    = '0;
        bus.b_valid   = 1'b0;
        bus.b_addr    = '0;
        bus.b_data    = '0;
        bus.chk_addr1 = '0;
        bus.chk_addr2 = '0;
        rst           = 1'b0;
        repeat (2) @(posedge clk);
        m_wen   = 1'b0;
        m_waddr = '0;
        m_wdata = '0;

        $display("[TB] reset held with a_valid high");
        applyStimulus(1'b0, 1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2, 5'd3, 5'd4);
        applyStimulus(1'b0, 1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2, 5'd3, 5'd4);

        $display("[TB] single write");
        applyStimulus(1'b1, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, '0, '0, 5'd3, 5'd0);
        idleCycles(4, 5'd3, 5'd0);

        $display("[TB] simultaneous A and B");
        applyStimulus(1'b1, 1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22, 5'd5, 5'd6);
        idleCycles(4, 5'd5, 5'd6);

        $display("[TB] zero address request");
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b1, 5'd0, 32'hFF, 5'd0, 5'd0);
        idleCycles(2, 5'd0, 5'd0);

        $display("[TB] backpressure and ordering");
        sendPair(5'd1, 32'hA1, 5'd2, 32'hB2);
        sendPair(5'd3, 32'hA3, 5'd4, 32'hB4);
        applyStimulus(1'b1, 1'b1, 5'd8, 32'hA8, 1'b1, 5'd9, 32'hB9, 5'd1, 5'd4);
        idleCycles(6, 5'd1, 5'd4);

        $display("[TB] hazard probe then mid-operation reset");
        applyStimulus(1'b1, 1'b1, 5'd7, 32'h77, 1'b0, '0, '0, 5'd0, 5'd7);
        idleCycles(3, 5'd0, 5'd7);
        sendPair(5'd1, 32'hC1, 5'd2, 32'hC2);
        sendPair(5'd3, 32'hC3, 5'd4, 32'hC4);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 5'd3, 5'd4);
        idleCycles(4, 5'd3, 5'd4);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 1500; n++) begin
            r  = ($urandom_range(0, 63) != 0);
            av = ($urandom_range(0, 3) != 0);
            bv = ($urandom_range(0, 3) != 0);
            aa = AW'($urandom_range(0, 7));
            ba = AW'($urandom_range(0, 7));
            ad = $urandom();
            bd = $urandom();
            c1 = AW'($urandom_range(0, 7));
            c2 = AW'($urandom_range(0, 7));
            applyStimulus(r, av, aa, ad, bv, ba, bd, c1, c2);
        end

        idleCycles(6, 5'd0, 5'd0);
        @(negedge clk);
        #3;
        compare("scoreboard_drain", 64'(expected.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
